// File: rtl/audio_dac_tx.sv
// -----------------------------------------------------------------------------
// audio_dac_tx
//
// I2S transmitter for the WM8731 DAC data line. The codec is bit-clock and
// frame master; BCLK and DACLRCK are resynchronised into the CLOCK_50 domain,
// where all state lives. Stereo sample pairs arrive through a valid/ready
// handshake into a one-pair holding buffer and are sent MSB first, one word per
// channel slot, in I2S alignment (MSB one BCLK after the LRCK change). A frame
// that starts with an empty buffer transmits silence and is counted.
//
// Ports
//   CLOCK_50       in   system clock
//   RESET_N        in   asynchronous active-low reset
//   BCLK           in   codec bit clock (asynchronous, oversampled)
//   DACLRCK        in   codec frame clock, 0 = left slot, 1 = right slot
//   DACDAT         out  serial data to codec, MSB first
//   leftSampleIn   in   signed left sample
//   rightSampleIn  in   signed right sample
//   sampleValid    in   sample pair valid
//   sampleReady    out  holding buffer empty; pair taken on valid && ready
//   frameStart     out  one-cycle pulse per detected left-frame start
//   underrun       out  one-cycle pulse when a frame starts with empty buffer
//   underrunCount  out  saturating underrun count
// -----------------------------------------------------------------------------
module audio_dac_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  BCLK,
  input  logic                  DACLRCK,
  output logic                  DACDAT,
  input  logic [DATA_WIDTH-1:0] leftSampleIn,
  input  logic [DATA_WIDTH-1:0] rightSampleIn,
  input  logic                  sampleValid,
  output logic                  sampleReady,
  output logic                  frameStart,
  output logic                  underrun,
  output logic [15:0]           underrunCount
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    LEFT,
    RIGHT
  } state_t;

  state_t state, next_state;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_d;
  logic                   bclk_rise;
  logic                   bclk_fall;

  // LRCK as seen on BCLK rising edges
  logic lrck_sampled;
  logic lrck_prev;
  logic eval;
  logic lrck_fall;
  logic lrck_rise;

  // Holding buffer
  logic [DATA_WIDTH-1:0] hold_l;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  full;
  logic                  accept;

  // Serialiser
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] right_word;
  logic [CNT_W-1:0]      bit_cnt;

  // FSM strobes
  logic load_left;
  logic load_right;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;
  assign bclk_fall = ~bclk_s & bclk_d;

  // The transition is judged one cycle after the rising edge that sampled
  // LRCK, so lrck_prev/lrck_sampled already hold the before/after pair.
  assign lrck_fall = lrck_prev & ~lrck_sampled;
  assign lrck_rise = ~lrck_prev & lrck_sampled;

  assign sampleReady = ~full;
  assign accept      = sampleValid & ~full;

  // ---------------------------------------------------------------------------
  // Clock-domain crossing and LRCK sampling
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync    <= '0;
      lrck_sync    <= '0;
      bclk_d       <= 1'b0;
      eval         <= 1'b0;
      lrck_sampled <= 1'b0;
      lrck_prev    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], DACLRCK};
      bclk_d    <= bclk_s;
      eval      <= bclk_rise;
      if (bclk_rise) begin
        lrck_sampled <= lrck_s;
        lrck_prev    <= lrck_sampled;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= WAIT_FRAME;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_left  = 1'b0;
    load_right = 1'b0;
    if (eval) begin
      case (state)
        WAIT_FRAME: begin
          // Only a left start aligns us; a right start here is ignored.
          if (lrck_fall) begin
            next_state = LEFT;
            load_left  = 1'b1;
          end
        end
        LEFT: begin
          if (lrck_fall) begin
            load_left = 1'b1;
          end else if (lrck_rise) begin
            next_state = RIGHT;
            load_right = 1'b1;
          end
        end
        RIGHT: begin
          if (lrck_fall) begin
            next_state = LEFT;
            load_left  = 1'b1;
          end
        end
        default: next_state = WAIT_FRAME;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Holding buffer
  // ---------------------------------------------------------------------------
  // A handshake is only possible while empty, so it never collides with the
  // left load clearing a full buffer; on an empty-buffer load the new pair
  // simply lands for the following frame.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_l <= '0;
      hold_r <= '0;
      full   <= 1'b0;
    end else begin
      if (accept) begin
        hold_l <= leftSampleIn;
        hold_r <= rightSampleIn;
        full   <= 1'b1;
      end else if (load_left) begin
        full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser, pulses and underrun counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      shift_reg     <= '0;
      right_word    <= '0;
      bit_cnt       <= CNT_W'(DATA_WIDTH);
      DACDAT        <= 1'b0;
      frameStart    <= 1'b0;
      underrun      <= 1'b0;
      underrunCount <= '0;
    end else begin
      frameStart <= load_left;
      underrun   <= load_left & ~full;

      if (load_left) begin
        bit_cnt <= '0;
        if (full) begin
          shift_reg  <= hold_l;
          right_word <= hold_r;
        end else begin
          shift_reg  <= '0;
          right_word <= '0;
          if (underrunCount != '1) begin
            underrunCount <= underrunCount + 16'd1;
          end
        end
      end else if (load_right) begin
        bit_cnt   <= '0;
        shift_reg <= right_word;
      end else if (bclk_fall) begin
        if (bit_cnt < CNT_W'(DATA_WIDTH)) begin
          DACDAT    <= shift_reg[DATA_WIDTH-1];
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end else begin
          DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_tx
//
// Codec-side model for audio_dac_tx: generates BCLK/DACLRCK frames, offers
// sample pairs, and captures DACDAT on BCLK rising edges. Expected slot words
// and frame events are queued by the stimulus and consumed by two monitors.
// -----------------------------------------------------------------------------
module tb_audio_dac_tx;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        BCLK;
  logic        DACLRCK;
  logic        DACDAT;
  logic [15:0] leftSampleIn;
  logic [15:0] rightSampleIn;
  logic        sampleValid;
  logic        sampleReady;
  logic        frameStart;
  logic        underrun;
  logic [15:0] underrunCount;

  audio_dac_tx #(
    .DATA_WIDTH (16),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .BCLK         (BCLK),
    .DACLRCK      (DACLRCK),
    .DACDAT       (DACDAT),
    .leftSampleIn (leftSampleIn),
    .rightSampleIn(rightSampleIn),
    .sampleValid  (sampleValid),
    .sampleReady  (sampleReady),
    .frameStart   (frameStart),
    .underrun     (underrun),
    .underrunCount(underrunCount)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        ur;
    logic [15:0] cnt;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] slot_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int fs_count = 0;
  int ur_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Word as captured over a 32-bit slot: one leftover zero, 16 data bits, 15 zeros.
  function automatic logic [31:0] slot_word(input logic [15:0] d);
    return {1'b0, d, 15'b0};
  endfunction

  task automatic expect_frame(input logic ur, input logic [15:0] cnt,
                              input logic [15:0] l, input logic [15:0] r);
    ev_t e;
    e.ur  = ur;
    e.cnt = cnt;
    ev_q.push_back(e);
    slot_q.push_back(slot_word(l));
    slot_q.push_back(slot_word(r));
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge CLOCK_50) begin
    if (frameStart || underrun) begin
      ev_t e;
      if (frameStart) fs_count++;
      if (underrun) ur_count++;
      if (ev_q.size() == 0) begin
        check("unexpected_frame_event", {15'b0, frameStart, 15'b0, underrun}, 32'h0);
      end else begin
        e = ev_q.pop_front();
        check("frame_start", frameStart, 1'b1);
        check("underrun_pulse", underrun, e.ur);
        check("underrun_count", underrunCount, e.cnt);
      end
    end
  end

  logic        mon_lr   = 1'b1;
  int          mon_cnt  = 0;
  logic [31:0] mon_word = '0;

  always @(posedge BCLK) begin
    if (DACLRCK !== mon_lr) begin
      mon_lr   = DACLRCK;
      mon_cnt  = 0;
      mon_word = '0;
    end
    if (mon_cnt < 32) begin
      mon_word = {mon_word[30:0], DACDAT};
      mon_cnt++;
      if (mon_cnt == 32) begin
        if (slot_q.size() == 0) begin
          check("unexpected_slot", mon_word, 32'h0);
        end else begin
          check("slot_word", mon_word, slot_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic lr_bits(input int n, input logic lr, input int h);
    for (int b = 0; b < n; b++) begin
      DACLRCK = lr;
      BCLK    = 1'b0;
      repeat (h) @(negedge CLOCK_50);
      BCLK = 1'b1;
      repeat (h) @(negedge CLOCK_50);
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r, input int min_fs);
    int waited;
    waited = 0;
    @(negedge CLOCK_50);
    #1;
    leftSampleIn  = l;
    rightSampleIn = r;
    sampleValid   = 1'b1;
    while (!sampleReady && waited < 5000) begin
      @(negedge CLOCK_50);
      #1;
      waited++;
    end
    check("offer_accepted", sampleReady, 1'b1);
    if (min_fs >= 0) check("held_until_left_load", fs_count >= min_fs, 1'b1);
    @(negedge CLOCK_50);
    #1;
    sampleValid = 1'b0;
  endtask

  // One frame of 2*slot_bits BCLK periods; LRCK changes with BCLK falling.
  task automatic gen_frame(input int slot_bits, input int h, input int rst_bit,
                           input int rel_bit, input bit hs_en,
                           input logic [15:0] hs_l, input logic [15:0] hs_r);
    for (int b = 0; b < 2 * slot_bits; b++) begin
      DACLRCK = (b >= slot_bits);
      BCLK    = 1'b0;
      if (b == rel_bit) RESET_N = 1'b1;
      repeat (h) @(negedge CLOCK_50);
      BCLK = 1'b1;
      if (hs_en && b == 0) begin
        repeat (3) @(negedge CLOCK_50);
        leftSampleIn  = hs_l;
        rightSampleIn = hs_r;
        sampleValid   = 1'b1;
        check("hs_ready_before_load", sampleReady, 1'b1);
        @(negedge CLOCK_50);
        sampleValid = 1'b0;
        check("hs_same_cycle_as_load", frameStart, 1'b1);
        check("hs_pair_captured", sampleReady, 1'b0);
        repeat (h - 4) @(negedge CLOCK_50);
      end else if (b == rst_bit) begin
        repeat (h / 2) @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        check("reset_dacdat_zero", DACDAT, 1'b0);
        check("reset_ready_high", sampleReady, 1'b1);
        repeat (h - h / 2) @(negedge CLOCK_50);
      end else begin
        repeat (h) @(negedge CLOCK_50);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int fs0;
    logic [15:0] sat_cnt[5];
    sat_cnt[0] = 16'hFFFD;
    sat_cnt[1] = 16'hFFFE;
    sat_cnt[2] = 16'hFFFF;
    sat_cnt[3] = 16'hFFFF;
    sat_cnt[4] = 16'hFFFF;

    RESET_N       = 1'b0;
    BCLK          = 1'b0;
    DACLRCK       = 1'b1;
    sampleValid   = 1'b0;
    leftSampleIn  = '0;
    rightSampleIn = '0;

    repeat (5) @(negedge CLOCK_50);
    check("rst_dacdat", DACDAT, 1'b0);
    check("rst_frame_start", frameStart, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_underrun_count", underrunCount, 16'h0);
    check("rst_ready", sampleReady, 1'b1);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("post_rst_ready", sampleReady, 1'b1);

    // First pair, offered before the first left start
    offer(16'h8001, 16'h7FFE, -1);
    lr_bits(4, 1'b1, 8);
    expect_frame(1'b0, 16'd0, 16'h8001, 16'h7FFE);
    gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);

    // Three starved frames
    for (int k = 1; k <= 3; k++) begin
      expect_frame(1'b1, 16'(k), 16'h0, 16'h0);
      gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);
    end
    check("underrun_count_after_3", underrunCount, 16'd3);
    check("underrun_pulses_after_3", ur_count, 3);

    // Back-to-back pairs: the second waits for the first left load
    expect_frame(1'b0, 16'd3, 16'h1111, 16'h2222);
    expect_frame(1'b0, 16'd3, 16'h3333, 16'h4444);
    fs0 = fs_count;
    fork
      begin
        offer(16'h1111, 16'h2222, -1);
        offer(16'h3333, 16'h4444, fs0 + 1);
      end
      begin
        gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);
        gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);
      end
    join

    // Reset in the left slot after 8 data bits, released inside the right slot
    offer(16'hA5C3, 16'h5A3C, -1);
    begin
      ev_t e;
      e.ur  = 1'b0;
      e.cnt = 16'd3;
      ev_q.push_back(e);
      slot_q.push_back(slot_word(16'hA5C3) & 32'hFF80_0000);
      slot_q.push_back(32'h0);
    end
    gen_frame(32, 8, 8, 40, 1'b0, 16'h0, 16'h0);
    check("no_underrun_after_reset", underrunCount, 16'd0);
    check("ready_after_midframe_reset", sampleReady, 1'b1);
    expect_frame(1'b0, 16'd0, 16'h0F0F, 16'hF0F0);
    offer(16'h0F0F, 16'hF0F0, -1);
    gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);

    // Handshake on the very cycle of an empty-buffer left load
    expect_frame(1'b1, 16'd1, 16'h0, 16'h0);
    expect_frame(1'b0, 16'd1, 16'h1234, 16'hFEDC);
    gen_frame(32, 8, -1, -1, 1'b1, 16'h1234, 16'hFEDC);
    gen_frame(32, 8, -1, -1, 1'b0, 16'h0, 16'h0);

    // Counter saturation with a fast BCLK, starting just below the limit
    force dut.underrunCount = 16'hFFFC;
    repeat (2) @(negedge CLOCK_50);
    release dut.underrunCount;
    @(negedge CLOCK_50);
    check("preload_count", underrunCount, 16'hFFFC);
    for (int k = 0; k < 5; k++) begin
      ev_t e;
      e.ur  = 1'b1;
      e.cnt = sat_cnt[k];
      ev_q.push_back(e);
      gen_frame(4, 4, -1, -1, 1'b0, 16'h0, 16'h0);
    end
    check("saturated_count", underrunCount, 16'hFFFF);

    lr_bits(2, 1'b1, 8);
    check("events_consumed", ev_q.size(), 0);
    check("slots_consumed", slot_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_dac_tx.md
# audio_dac_tx

Serializes stereo 16-bit sample pairs from the effects chain onto the WM8731 DAC data line in I2S format, with the codec as bit-clock and frame master. It sits between the effect modules' `leftSampleOut`/`rightSampleOut` and the codec `DACDAT` pin. It is the output-side counterpart of the `ADCLRCK`-driven sample consumers. Samples enter on the system clock through a valid/ready handshake into a one-pair holding buffer; underruns transmit silence and are counted.

## Interface
- `DATA_WIDTH`, 16, bits per channel word.
- `SYNC_STAGES`, 2, flip-flop stages on `BCLK` and `DACLRCK`; minimum 2.
- `CLOCK_50` input 1: system clock; all state is in this domain.
- `RESET_N` input 1: asynchronous, active-low reset.
- `BCLK` input 1: codec bit clock, asynchronous; oversampled.
- `DACLRCK` input 1: codec frame clock, asynchronous; 0 = left, 1 = right.
- `DACDAT` output 1: serial data to codec, MSB first.
- `leftSampleIn` input DATA_WIDTH: signed left sample.
- `rightSampleIn` input DATA_WIDTH: signed right sample.
- `sampleValid` input 1: pair on sample inputs is valid.
- `sampleReady` output 1: holding buffer empty; the pair is accepted when `sampleValid && sampleReady` on a `CLOCK_50` edge.
- `frameStart` output 1: one-cycle pulse at each detected left-frame start.
- `underrun` output 1: one-cycle pulse when a frame starts with an empty buffer.
- `underrunCount` output 16: saturating count of underruns.

## Operation
- `BCLK` and `DACLRCK` pass through `SYNC_STAGES` flops.
- Rising and falling edges of the synced `BCLK` are detected against a one-cycle-delayed copy.
- `DACLRCK` is sampled only on synced `BCLK` rising edges, giving `lrckSampled`; the previous value is kept in `lrckPrev`.
- Holding buffer: `holdL`, `holdR`, and a `full` flag.
  - `sampleReady = !full`; this is combinational from the register.
  - On a handshake, `holdL` and `holdR` capture the inputs and `full` is set to 1.
- State machine, with transitions evaluated on a synced `BCLK` rising edge:
  - WAIT_FRAME: entered from reset. Moves to LEFT on `lrckPrev=1, lrckSampled=0`. Right-channel starts (0→1) are ignored.
  - LEFT: on 1→0 it stays in LEFT with a new frame; on 0→1 it goes to RIGHT.
  - RIGHT: on 1→0 it goes to LEFT.
- Left-frame start (1→0 detected):
  - `frameStart` pulses.
  - If `full`, `shiftReg` is loaded with `holdL`, `rightWord` is loaded with `holdR`, and `full` is cleared.
  - Otherwise `shiftReg` and `rightWord` are loaded with 0, `underrun` pulses, and `underrunCount` increments unless it is 0xFFFF.
- Right-frame start (0→1, in LEFT): `shiftReg` is loaded with `rightWord`.
- `bitCnt` resets to 0 at each frame start.
- On each synced `BCLK` falling edge after a frame start:
  - While `bitCnt < DATA_WIDTH`: `DACDAT` is set to `shiftReg[MSB]`, the register shifts left, and `bitCnt` increments.
  - Once `bitCnt = DATA_WIDTH`: `DACDAT` is 0 for the rest of the channel slot.
- The left and right words of a frame always come from the same accepted pair.
- A handshake on the same cycle as a left-frame load:
  - The load uses the old buffer contents, or 0 if the buffer was empty.
  - The new pair fills the buffer for the next frame.
  - When the buffer was full, `sampleReady` was 0 on that cycle, so no handshake is possible.
- No arithmetic on sample data; words are passed bit-exact.

## Timing
- Reset values: `DACDAT`=0, `frameStart`=0, `underrun`=0, `underrunCount`=0, `full`=0. `sampleReady` reads 1 during and after reset. State is WAIT_FRAME.
- Reset mid-frame: `DACDAT` goes to 0 immediately. Nothing is transmitted until the next left-frame start, and no underrun is counted before it.
- I2S alignment:
  - The MSB is driven on the first `BCLK` falling edge after the `BCLK` rising edge at which the LRCK change is seen.
  - The codec therefore samples the MSB on the 2nd `BCLK` rising edge after the LRCK transition.
- Input-to-output skew: `DACDAT` changes `SYNC_STAGES`+1 `CLOCK_50` cycles after a `BCLK` falling edge.
  - Requirement: `BCLK` half-period ≥ `SYNC_STAGES`+2 `CLOCK_50` periods.
  - For WM8731 at 48 kHz, 64 × fs, the half-period is about 8 cycles, which meets this.
- Pair latency: a pair accepted before a left-frame-start detection is transmitted in that frame. Its MSB appears about one `BCLK` period later.
- `sampleReady` returns to 1 in the cycle after the left load.

## Test plan
- Reset, then drive 64-`BCLK` frames (32 per channel) and offer pair L=0x8001, R=0x7FFE before the first left start. Required:
  - The `DACDAT` bits captured on `BCLK` rising edges in the left slot read 1000_0000_0000_0001 starting at the 2nd rising edge.
  - The right slot reads 0x7FFE.
  - The other 16 bits in each slot are 0.
- Keep `sampleValid` low for 3 frames. Required: 3 `underrun` pulses, `underrunCount`=3, all-zero `DACDAT`, 3 `frameStart` pulses.
- Offer pairs (0x1111,0x2222) and (0x3333,0x4444) back to back. Required:
  - The second pair is held off with `sampleReady`=0 until the first left load.
  - The frames carry the pairs in order with no underrun.
- Assert `RESET_N` low in the middle of the left slot, then release it while `DACLRCK`=1. Required:
  - `DACDAT` is 0 at once.
  - The right start is ignored.
  - Transmission resumes only at the next 1→0 transition, with no underrun counted before it.
- Handshake in the same `CLOCK_50` cycle as a left-frame load with an empty buffer. Required:
  - The current frame underruns and is zero.
  - The new pair appears in the next frame.
- Force 65540 underruns via a fast `BCLK`. Required: `underrunCount` saturates at 0xFFFF.
